// File: rtl/sipo_ctrl_pkg.sv
// Shared types and sizing helpers for the SIPO frame controller.
package sipo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned CNT_W_MAX = $clog2(WIDTH_MAX + 1);

    // Counter must hold 0..WIDTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_controller_if.sv
// Serial-in / word-out signal bundle between the link front end, the framer and the consumer.
interface sipo_frame_controller_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_in;
    logic             data_in;
    logic             out_ready;
    logic             ovr_clr;
    logic [WIDTH-1:0] par_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start_in, data_in, out_ready, ovr_clr,
        input  par_out, out_valid, busy, overrun
    );

    modport slave (
        input  start_in, data_in, out_ready, ovr_clr,
        output par_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// Gated serial-in parallel-out shift register; direction chosen by MSB_FIRST.
module sipo_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             data_in,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], data_in};
            else           sr_d = {data_in, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign q = sr_q;
endmodule

// File: rtl/sipo_frame_controller.sv
// Frames a serial stream into WIDTH-bit words and hands them off on valid/ready,
// with a sticky overrun flag for words dropped while the output slot is full.
module sipo_frame_controller
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    sipo_frame_controller_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             shift_en;
    logic             word_done;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .data_in  (bus.data_in),
        .q        (sr)
    );

    // Completed word includes the bit arriving on the final edge.
    always_comb begin
        if (MSB_FIRST) word = {sr[WIDTH-2:0], bus.data_in};
        else           word = {bus.data_in, sr[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        word_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    shift_en = 1'b1;
                    cnt_d    = CW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        par_d   = par_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (bus.ovr_clr) ovr_d = 1'b0;
        if (word_done) begin
            if (!valid_q || bus.out_ready) begin
                par_d   = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.par_out   = par_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_frame_controller;

    logic clk = 1'b0;
    logic rst, start_r, data_r, ready_r, clr_r;

    always #5 clk = ~clk;

    sipo_frame_controller_if #(.WIDTH(8)) bm ();
    sipo_frame_controller_if #(.WIDTH(8)) bl ();

    assign bm.start_in  = start_r;
    assign bm.data_in   = data_r;
    assign bm.out_ready = ready_r;
    assign bm.ovr_clr   = clr_r;
    assign bl.start_in  = start_r;
    assign bl.data_in   = data_r;
    assign bl.out_ready = ready_r;
    assign bl.ovr_clr   = clr_r;

    sipo_frame_controller #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    sipo_frame_controller #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bl)
    );

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    typedef struct {
        logic [7:0] w;
        int         c;
    } acc_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt;
    int   stay_ok;
    acc_t acc_q[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Logs accepted words (handshake seen just before the edge) with their cycle.
    task automatic tick();
        if (bm.out_valid && bm.out_ready) acc_q.push_back('{w: bm.par_out, c: cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_frame(input logic [7:0] w);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            start_r = (i == 0);
            data_r  = w[7-i];
            tick();
            busy_cnt += int'(bm.busy);
        end
        start_r = 1'b0;
        data_r  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hB2, 8'hB2, 8'h4D};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[3] = '{8'h0F, 8'h0F, 8'hF0};
        vecs[4] = '{8'h01, 8'h01, 8'h80};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[6] = '{8'h00, 8'h00, 8'h00};
        vecs[7] = '{8'h96, 8'h96, 8'h69};

        rst = 1'b1; start_r = 1'b0; data_r = 1'b0; ready_r = 1'b0; clr_r = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_valid", {30'd0, bm.out_valid, bl.out_valid}, 32'd0);
        chk("reset_par",   {16'd0, bm.par_out, bl.par_out}, 32'd0);
        chk("reset_busy",  {30'd0, bm.busy, bl.busy}, 32'd0);
        chk("reset_ovr",   {30'd0, bm.overrun, bl.overrun}, 32'd0);

        // Single frames in both bit orders, consumer always ready.
        ready_r = 1'b1;
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].word);
            chk("tbl_par_msb", 32'(bm.par_out), 32'(vecs[v].exp_msb));
            chk("tbl_par_lsb", 32'(bl.par_out), 32'(vecs[v].exp_lsb));
            chk("tbl_valid",   {30'd0, bm.out_valid, bl.out_valid}, 32'd3);
            chk("tbl_busy_cycles", 32'(busy_cnt), 32'd7);
            chk("tbl_busy_end", 32'(bm.busy), 32'd0);
            tick();
            chk("tbl_valid_one_cycle", {30'd0, bm.out_valid, bl.out_valid}, 32'd0);
            chk("tbl_ovr", {30'd0, bm.overrun, bl.overrun}, 32'd0);
        end

        // Back-to-back frames: two words accepted 8 cycles apart.
        acc_q.delete();
        send_frame(8'hA5);
        send_frame(8'h3C);
        tick();
        chk("b2b_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            chk("b2b_word0", 32'(acc_q[0].w), 32'hA5);
            chk("b2b_word1", 32'(acc_q[1].w), 32'h3C);
            chk("b2b_spacing", 32'(acc_q[1].c - acc_q[0].c), 32'd8);
        end

        // Stalled consumer: second word dropped, overrun sticky until cleared.
        ready_r = 1'b0;
        send_frame(8'hA5);
        chk("stall_first_valid", 32'(bm.out_valid), 32'd1);
        chk("stall_first_ovr", 32'(bm.overrun), 32'd0);
        send_frame(8'h3C);
        chk("stall_par_held", 32'(bm.par_out), 32'hA5);
        chk("stall_ovr_set", {30'd0, bm.overrun, bl.overrun}, 32'd3);
        tick(); tick();
        chk("stall_ovr_sticky", 32'(bm.overrun), 32'd1);
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        chk("ovr_clr", 32'(bm.overrun), 32'd0);
        chk("ovr_clr_valid_kept", 32'(bm.out_valid), 32'd1);
        // Clear held through a dropping completion: the set must win.
        clr_r = 1'b1;
        send_frame(8'h11);
        clr_r = 1'b0;
        chk("ovr_set_wins", 32'(bm.overrun), 32'd1);
        chk("ovr_set_wins_par", 32'(bm.par_out), 32'hA5);
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        ready_r = 1'b1; tick();
        chk("drain_valid", 32'(bm.out_valid), 32'd0);
        chk("drain_par_hold", 32'(bm.par_out), 32'hA5);

        // Reset arriving on bit 4 aborts the frame cleanly.
        acc_q.delete();
        for (int i = 0; i < 4; i++) begin
            start_r = (i == 0);
            data_r  = 1'b1;
            tick();
        end
        start_r = 1'b0;
        rst = 1'b1; data_r = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", {30'd0, bm.busy, bl.busy}, 32'd0);
        chk("abort_valid", {30'd0, bm.out_valid, bl.out_valid}, 32'd0);
        chk("abort_par", 32'(bm.par_out), 32'd0);
        data_r = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_word", 32'(acc_q.size()), 32'd0);
        chk("abort_idle_busy", 32'(bm.busy), 32'd0);
        send_frame(8'h0F);
        chk("after_abort_msb", 32'(bm.par_out), 32'h0F);
        chk("after_abort_lsb", 32'(bl.par_out), 32'hF0);
        tick();
        chk("after_abort_count", 32'(acc_q.size()), 32'd1);

        // Word pending, stray starts mid-frame, ready only on the completion edge.
        ready_r = 1'b0;
        send_frame(8'hA5);
        stay_ok  = 1;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w       = 8'h3C;
            start_r = (i == 0) || (i == 3) || (i == 5);
            data_r  = w[7-i];
            ready_r = (i == 7);
            tick();
            busy_cnt += int'(bm.busy);
            if (!bm.out_valid) stay_ok = 0;
        end
        start_r = 1'b0; data_r = 1'b0; ready_r = 1'b0;
        chk("nobubble_valid_always", 32'(stay_ok), 32'd1);
        chk("nobubble_par", 32'(bm.par_out), 32'h3C);
        chk("nobubble_ovr", 32'(bm.overrun), 32'd0);
        chk("nobubble_busy_cycles", 32'(busy_cnt), 32'd7);
        tick();
        chk("nobubble_held", 32'(bm.out_valid), 32'd1);
        chk("nobubble_busy_idle", 32'(bm.busy), 32'd0);
        ready_r = 1'b1; tick();
        chk("nobubble_drain", 32'(bm.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
